// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed multiplier.
package mult_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/done handshake and operand/result bus of mult_seq.
interface mult_seq_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] p;
  logic             overflow;

  modport master (output start, a, b, input busy, done, p, overflow);
  modport slave  (input start, a, b, output busy, done, p, overflow);

endinterface

// File: rtl/mult_seq_mag_neg.sv
// Conditional two's-complement negate; the magnitude of the most negative
// value comes out as its unsigned bit pattern.
module mag_neg #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_neg_en,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_neg_en ? -i_in : i_in;

endmodule

// File: rtl/mult_seq.sv
// Radix-2 shift-and-add signed multiplier: WIDTH RUN cycles plus one FIX cycle.
// Optional build macro MULT_SEQ_SAT_EN saturates p when overflow is flagged.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  mult_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_done;
  logic [WIDTH-1:0] r_p;
  logic             r_ovf;

  logic [WIDTH-1:0] w_abs [2];
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_fix;
  logic [WIDTH-1:0] w_p_fix;
  logic             w_ovf;

  // Operand magnitudes: index 0 is a, index 1 is b.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_abs
      logic [WIDTH-1:0] w_op;
      assign w_op = (gi == 0) ? bus.a : bus.b;
      mag_neg #(.WIDTH(WIDTH)) u_abs (
        .i_in     (w_op),
        .i_neg_en (w_op[WIDTH-1]),
        .o_out    (w_abs[gi])
      );
    end
  endgenerate

  assign w_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_mcand} : '0);

  mag_neg #(.WIDTH(WIDTH)) u_fix (
    .i_in     (r_mq),
    .i_neg_en (r_neg),
    .o_out    (w_fix)
  );

  // A negative result of magnitude exactly 2^(WIDTH-1) is still representable.
  assign w_ovf = (r_acc != '0) |
                 (r_mq[WIDTH-1] & ~(r_neg & (r_mq[WIDTH-2:0] == '0)));

`ifdef MULT_SEQ_SAT_EN
  assign w_p_fix = !w_ovf ? w_fix :
                   r_neg  ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_p_fix = w_fix;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (r_cnt == CW'(WIDTH-1)) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_p     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mcand <= w_abs[0];
            r_mq    <= w_abs[1];
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          end
        end
        RUN: begin
          r_acc <= w_sum[WIDTH:1];
          r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_p    <= w_p_fix;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.p        = r_p;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed corner cases, randomized operands,
// busy-time restart, back-to-back start and mid-run reset.
module tb_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mult_seq_if #(.WIDTH(16)) bus ();

  mult_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed product, then range test and truncation/saturation.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] ep, output logic eo);
    int sa, sb, prod;
    sa   = $signed(a);
    sb   = $signed(b);
    prod = sa * sb;
    eo   = (prod > 32767) || (prod < -32768);
    ep   = prod[15:0];
`ifdef MULT_SEQ_SAT_EN
    if (eo) ep = (prod < 0) ? 16'h8000 : 16'h7FFF;
`endif
  endfunction

  // Called at a negedge; start is raised for one cycle. Returns at the negedge
  // where done is seen (or after the cycle budget expires).
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input bit inject,
                          output int lat, output int nbusy, output int done_cyc);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    lat = 0;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      if (inject && lat == 5) begin
        bus.start = 1'b1;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    done_cyc = cyc;
  endtask

  task automatic do_case(input logic [15:0] a, input logic [15:0] b, input bit inject,
                         input bit timing);
    logic [15:0] ep;
    logic        eo;
    int          lat, nbusy, dc;
    model(a, b, ep, eo);
    run_mult(a, b, inject, lat, nbusy, dc);
    $display("[TB] a=%h b=%h -> p=%h ovf=%0b (exp p=%h ovf=%0b) lat=%0d",
             a, b, bus.p, bus.overflow, ep, eo, lat);
    check("done_seen", 32'(bus.done), 32'd1);
    check("p", 32'(bus.p), 32'(ep));
    check("overflow", 32'(bus.overflow), 32'(eo));
    if (timing) begin
      check("latency", 32'(lat), 32'd17);
      check("busy_cycles", 32'(nbusy), 32'd17);
      check("busy_at_done", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    check("done_width", 32'(bus.done), 32'd0);
    check("p_hold", 32'(bus.p), 32'(ep));
  endtask

  logic [15:0] dir_a [9] = '{16'd3, 16'hFFF9, 16'd0, 16'h8000, 16'h8000,
                             16'd200, 16'hFF38, 16'hFFFF, 16'h7FFF};
  logic [15:0] dir_b [9] = '{16'd5, 16'd6, 16'hFFF7, 16'd1, 16'hFFFF,
                             16'd200, 16'd200, 16'h8000, 16'h7FFF};

  initial begin
    logic [15:0] ep1, ep2;
    logic        eo1, eo2;
    int          lat, nbusy, dc1, dc2, seen;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_p", 32'(bus.p), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) do_case(dir_a[i], dir_b[i], 1'b0, 1'b1);

    // Restart attempt while busy must be ignored.
    do_case(16'hFFF9, 16'd6, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if (i % 5 == 0) rb = -rb;
      do_case(ra, rb, 1'b0, 1'b0);
    end

    // Back-to-back: second start issued in the cycle done is high.
    model(16'd1234, 16'hFFFD, ep1, eo1);
    model(16'h4000, 16'd4, ep2, eo2);
    run_mult(16'd1234, 16'hFFFD, 1'b0, lat, nbusy, dc1);
    check("b2b_p1", 32'(bus.p), 32'(ep1));
    run_mult(16'h4000, 16'd4, 1'b0, lat, nbusy, dc2);
    $display("[TB] back-to-back done spacing=%0d p=%h ovf=%0b", dc2 - dc1, bus.p, bus.overflow);
    check("b2b_spacing", 32'(dc2 - dc1), 32'd18);
    check("b2b_p2", 32'(bus.p), 32'(ep2));
    check("b2b_ovf2", 32'(bus.overflow), 32'(eo2));
    @(negedge clk);

    // Reset at RUN cycle 8 after a nonzero, overflowing result is held.
    do_case(16'd200, 16'd200, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.a = 16'd77;
    bus.b = 16'd99;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] mid-run reset busy=%0b done=%0b p=%h ovf=%0b",
             bus.busy, bus.done, bus.p, bus.overflow);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_p", 32'(bus.p), 32'd0);
    check("arst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    do_case(16'hFFF9, 16'd6, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
